odd_p_check_4bit: RTL and testbench

Odd-parity checker for a 4-bit data nibble with its accompanying parity bit, placed at the receive side of a nibble-wide link. Each valid input beat is checked so that the five bits `{i, p}` carry an odd number of ones. The block registers a per-beat pass/fail flag, keeps a sticky error flag, and counts errors for status readout.

---
 rtl/odd_parity_pkg.sv | 16 +
 rtl/odd_p_check_4bit_parity_reduce.sv | 13 +
 rtl/odd_p_check_4bit.sv | 61 ++++++
 tb/tb_odd_p_check_4bit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/odd_parity_pkg.sv
// Shared constants and the reference odd-parity error function
// for the nibble-wide receive link.
package odd_parity_pkg;

    localparam int DATA_W = 4;

    localparam logic PC_ERR = 1'b1;
    localparam logic PC_OK  = 1'b0;

    // The five bits {data, par} must hold an odd number of ones.
    // An even count is reported as an error.
    function automatic logic odd_par_err(input logic [DATA_W-1:0] data, input logic par);
        return ~(^{data, par});
    endfunction

endpackage

// File: rtl/odd_p_check_4bit_parity_reduce.sv
// Pure combinational XOR-reduce of a nibble and its parity bit,
// producing the parity-error flag for the current beat.
module parity_reduce
    import odd_parity_pkg::*;
(
    input  logic [DATA_W-1:0] i,
    input  logic              p,
    output logic              pc_next
);

    assign pc_next = odd_par_err(i, p);

endmodule

// File: rtl/odd_p_check_4bit.sv
// Receive-side odd-parity checker: registers the per-beat result and
// tracks a sticky error flag plus a saturating error count.
module odd_p_check_4bit
    import odd_parity_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i,
    input  logic              p,
    input  logic              in_valid,
    input  logic              clr,
    output logic              pc,
    output logic              pc_valid,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_cnt
);

    logic pc_next;
    logic beat_err;
    logic cnt_full;

    parity_reduce u_parity_reduce (
        .i       (i),
        .p       (p),
        .pc_next (pc_next)
    );

    assign beat_err = in_valid && (pc_next == PC_ERR);
    assign cnt_full = (err_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= PC_OK;
            pc_valid <= 1'b0;
        end else begin
            pc_valid <= in_valid;
            if (in_valid) begin
                pc <= pc_next;
            end
        end
    end

    // Clear takes priority over an error beat arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (beat_err) begin
            err_sticky <= 1'b1;
            if (!cnt_full) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_odd_p_check_4bit.sv
// Directed self-checking bench for odd_p_check_4bit, with a second
// narrow-counter instance sharing the same inputs for saturation checks.
module tb_odd_p_check_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic       p;
    logic       in_valid;
    logic       clr;

    logic       pc;
    logic       pc_valid;
    logic       err_sticky;
    logic [7:0] err_cnt;

    logic       pc3;
    logic       pc_valid3;
    logic       err_sticky3;
    logic [2:0] err_cnt3;

    int checks = 0;
    int errors = 0;

    odd_p_check_4bit #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i),
        .p          (p),
        .in_valid   (in_valid),
        .clr        (clr),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    odd_p_check_4bit #(.CNT_W(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i          (i),
        .p          (p),
        .in_valid   (in_valid),
        .clr        (clr),
        .pc         (pc3),
        .pc_valid   (pc_valid3),
        .err_sticky (err_sticky3),
        .err_cnt    (err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one beat away from the edge, then return just after the sampling edge.
    task automatic applyStimulus(input logic [3:0] d, input logic par, input logic v, input logic c);
        @(negedge clk);
        i        = d;
        p        = par;
        in_valid = v;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] vec;
        logic       exp_pc;
        int         n_err;

        rst_n    = 1'b0;
        i        = 4'h0;
        p        = 1'b0;
        in_valid = 1'b0;
        clr      = 1'b0;

        $display("[TB] reset with random inputs");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            checkOutput("rst_pc", 32'(pc), 32'h0);
            checkOutput("rst_pc_valid", 32'(pc_valid), 32'h0);
            checkOutput("rst_sticky", 32'(err_sticky), 32'h0);
            checkOutput("rst_cnt", 32'(err_cnt), 32'h0);
        end

        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b1;
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_pc", 32'(pc), 32'h0);
        checkOutput("idle_pc_valid", 32'(pc_valid), 32'h0);
        checkOutput("idle_cnt", 32'(err_cnt), 32'h0);

        $display("[TB] directed beats");
        applyStimulus(4'b0010, 1'b0, 1'b1, 1'b0);
        checkOutput("dir0_pc", 32'(pc), 32'h0);
        checkOutput("dir0_pc_valid", 32'(pc_valid), 32'h1);
        applyStimulus(4'b0011, 1'b1, 1'b1, 1'b0);
        checkOutput("dir1_pc", 32'(pc), 32'h0);
        checkOutput("dir1_pc_valid", 32'(pc_valid), 32'h1);
        applyStimulus(4'b0111, 1'b1, 1'b1, 1'b0);
        checkOutput("dir2_pc", 32'(pc), 32'h1);
        checkOutput("dir2_pc_valid", 32'(pc_valid), 32'h1);
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        checkOutput("dir3_pc", 32'(pc), 32'h1);
        checkOutput("dir3_pc_valid", 32'(pc_valid), 32'h1);
        checkOutput("dir_cnt", 32'(err_cnt), 32'd2);
        checkOutput("dir_sticky", 32'(err_sticky), 32'h1);
        checkOutput("dir_cnt3", 32'(err_cnt3), 32'd2);

        applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_idle_cnt", 32'(err_cnt), 32'h0);
        checkOutput("clr_idle_sticky", 32'(err_sticky), 32'h0);
        checkOutput("clr_idle_pc_hold", 32'(pc), 32'h1);
        checkOutput("clr_idle_pc_valid", 32'(pc_valid), 32'h0);

        $display("[TB] exhaustive sweep");
        for (int k = 0; k < 32; k++) begin
            vec    = 5'(k);
            exp_pc = (($countones(vec) % 2) == 0);
            applyStimulus(vec[4:1], vec[0], 1'b1, 1'b0);
            checkOutput($sformatf("sweep_pc_%0d", k), 32'(pc), 32'(exp_pc));
        end
        checkOutput("sweep_cnt", 32'(err_cnt), 32'd16);
        checkOutput("sweep_cnt3_sat", 32'(err_cnt3), 32'd7);
        checkOutput("sweep_sticky", 32'(err_sticky), 32'h1);

        $display("[TB] saturation");
        applyStimulus(4'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("sat_clr_cnt3", 32'(err_cnt3), 32'h0);
        n_err = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
            n_err++;
            checkOutput($sformatf("sat_cnt3_%0d", k), 32'(err_cnt3), 32'((n_err > 7) ? 7 : n_err));
            checkOutput($sformatf("sat_cnt_%0d", k), 32'(err_cnt), 32'(n_err));
        end
        checkOutput("sat_sticky3", 32'(err_sticky3), 32'h1);

        $display("[TB] clear with error beat, then hold");
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("clr_err_sticky", 32'(err_sticky), 32'h0);
        checkOutput("clr_err_pc", 32'(pc), 32'h1);
        checkOutput("clr_err_pc_valid", 32'(pc_valid), 32'h1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_pc", 32'(pc), 32'h1);
        checkOutput("hold_pc_valid", 32'(pc_valid), 32'h0);
        checkOutput("hold_cnt", 32'(err_cnt), 32'h0);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'b1001, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_arst_cnt", 32'(err_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pc", 32'(pc), 32'h0);
        checkOutput("arst_pc_valid", 32'(pc_valid), 32'h0);
        checkOutput("arst_sticky", 32'(err_sticky), 32'h0);
        checkOutput("arst_cnt", 32'(err_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_arst_pc", 32'(pc), 32'h1);
        checkOutput("post_arst_cnt", 32'(err_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
